// File: rtl/asmi_arbiter.sv
// ---------------------------------------------------------------------------
// asmi_arbiter
//
// Shares one ASMI flash-programming macro between two requesters:
//   port A - firmware updater (sector erase, page write)
//   port B - flash reader (configuration / verify reads)
//
// Only one port owns the ASMI at a time. The owner's strobes are multiplexed
// onto the macro; the other port's strobes are ignored. Ownership never
// changes while the flash reports busy. After every release (and after
// reset) the arbiter waits BUSY_SETTLE cycles for a late busy flag, then for
// busy to drop, then HOLDOFF idle cycles, before it arbitrates again.
//
// Optional feature (macro ASMI_ARB_TIMEOUT_EN):
//   A 25-bit grant watchdog revokes a grant held for TIMEOUT cycles and sets
//   the sticky timeout_err flag. The timed-out port must drop and re-raise
//   its request before it can be granted again. Without the macro, grants
//   are unbounded and timeout_err is tied low.
//
// Parameters:
//   BUSY_SETTLE  cycles after release before asmi_busy is trusted
//   HOLDOFF      idle cycles forced between consecutive grants
//   TIMEOUT      watchdog limit in cycles (macro builds only)
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   a_req / b_req            ownership requests, held for the transaction
//   a_gnt / b_gnt            registered grants, never both high
//   a_addr / b_addr          24-bit flash byte addresses
//   a_sector_erase, a_wren,
//   a_write, a_shift_bytes   port A strobes
//   a_datain                 port A write data (already bit-reversed)
//   b_read, b_rden           port B read strobes
//   asmi_*                   gated address / strobes / data to the ASMI
//   asmi_busy                busy flag from the ASMI
//   busy_out                 high whenever the arbiter is not idle
//   timeout_err              sticky watchdog flag
// ---------------------------------------------------------------------------
module asmi_arbiter #(
    parameter int unsigned BUSY_SETTLE = 3,
    parameter int unsigned HOLDOFF     = 2,
    parameter int unsigned TIMEOUT     = 25000000
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        a_req,
    input  logic        b_req,
    output logic        a_gnt,
    output logic        b_gnt,

    input  logic [23:0] a_addr,
    input  logic [23:0] b_addr,

    input  logic        a_sector_erase,
    input  logic        a_wren,
    input  logic        a_write,
    input  logic        a_shift_bytes,
    input  logic [7:0]  a_datain,

    input  logic        b_read,
    input  logic        b_rden,

    output logic [23:0] asmi_addr,
    output logic        asmi_sector_erase,
    output logic        asmi_wren,
    output logic        asmi_write,
    output logic        asmi_shift_bytes,
    output logic        asmi_read,
    output logic        asmi_rden,
    output logic [7:0]  asmi_datain,

    input  logic        asmi_busy,
    output logic        busy_out,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GNT_A,
        S_GNT_B,
        S_SETTLE,
        S_DRAIN,
        S_GAP
    } state_t;

    typedef enum logic {
        OWNER_A,
        OWNER_B
    } owner_t;

    // One shared phase counter serves both SETTLE and GAP; it is sized for
    // the longer of the two and saturates rather than wrapping.
    localparam int unsigned CNT_MAX = (BUSY_SETTLE > HOLDOFF) ? BUSY_SETTLE : HOLDOFF;
    localparam int          CNT_W   = $clog2(CNT_MAX + 2);

    // A zero-length phase still occupies one cycle, so the last count is 0.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((BUSY_SETTLE > 0) ? BUSY_SETTLE - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_t           last_owner_q, last_owner_d;

    // Requests as seen by arbitration (a timed-out port is masked until it
    // drops its request) and the watchdog revoke strobe.
    logic a_req_eff;
    logic b_req_eff;
    logic wd_expire;

`ifdef ASMI_ARB_TIMEOUT_EN
    localparam logic [24:0] WD_LAST = 25'(TIMEOUT - 1);

    logic [24:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        a_block_q, a_block_d;
    logic        b_block_q, b_block_d;

    // The watchdog only runs while a grant is held and restarts from zero on
    // every new grant. A revoke locks the offending port out until its
    // request has been seen low at least once.
    always_comb begin
        wd_cnt_d      = '0;
        wd_expire     = 1'b0;
        if (state_q == S_GNT_A || state_q == S_GNT_B) begin
            wd_expire = (wd_cnt_q >= WD_LAST);
            wd_cnt_d  = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 25'd1;
        end
        timeout_err_d = timeout_err_q | wd_expire;
        a_block_d     = a_req & (a_block_q | (wd_expire & (state_q == S_GNT_A)));
        b_block_d     = b_req & (b_block_q | (wd_expire & (state_q == S_GNT_B)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            a_block_q     <= 1'b0;
            b_block_q     <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
            a_block_q     <= a_block_d;
            b_block_q     <= b_block_d;
        end
    end

    assign a_req_eff   = a_req & ~a_block_q;
    assign b_req_eff   = b_req & ~b_block_q;
    assign timeout_err = timeout_err_q;
`else
    // Watchdog compiled out: TIMEOUT has no effect in this build.
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;

    assign wd_expire   = 1'b0;
    assign a_req_eff   = a_req;
    assign b_req_eff   = b_req;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic. Every release path (req drop, watchdog, reset) goes
    // through SETTLE -> DRAIN -> GAP so that an operation already started in
    // the flash is always waited out before ownership can move.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // On a tie the port that did not own the ASMI last wins.
                if (a_req_eff && (!b_req_eff || last_owner_q == OWNER_B)) begin
                    state_d      = S_GNT_A;
                    last_owner_d = OWNER_A;
                end else if (b_req_eff) begin
                    state_d      = S_GNT_B;
                    last_owner_d = OWNER_B;
                end
            end

            S_GNT_A: begin
                cnt_d = '0;
                if (!a_req || wd_expire) begin
                    state_d = S_SETTLE;
                end
            end

            S_GNT_B: begin
                cnt_d = '0;
                if (!b_req || wd_expire) begin
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                end
            end

            S_DRAIN: begin
                cnt_d = '0;
                if (!asmi_busy) begin
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset lands in SETTLE rather than IDLE: the flash may still be busy
    // with an operation issued before reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_SETTLE;
            cnt_q        <= '0;
            last_owner_q <= OWNER_B;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Grants and busy are decoded straight from the state register, so they
    // are registered and drop on the same edge the FSM leaves a grant state.
    assign a_gnt    = (state_q == S_GNT_A);
    assign b_gnt    = (state_q == S_GNT_B);
    assign busy_out = (state_q != S_IDLE);

    // Strobe mux keyed on the registered grant. Port B has no write-side
    // strobes and port A has no read strobes; those outputs stay low.
    always_comb begin
        asmi_addr         = '0;
        asmi_sector_erase = 1'b0;
        asmi_wren         = 1'b0;
        asmi_write        = 1'b0;
        asmi_shift_bytes  = 1'b0;
        asmi_read         = 1'b0;
        asmi_rden         = 1'b0;
        asmi_datain       = '0;

        case (state_q)
            S_GNT_A: begin
                asmi_addr         = a_addr;
                asmi_sector_erase = a_sector_erase;
                asmi_wren         = a_wren;
                asmi_write        = a_write;
                asmi_shift_bytes  = a_shift_bytes;
                asmi_datain       = a_datain;
            end
            S_GNT_B: begin
                asmi_addr = b_addr;
                asmi_read = b_read;
                asmi_rden = b_rden;
            end
            default: begin
            end
        endcase
    end

endmodule
